// File: rtl/score_accumulator.sv
// BCD score accumulator: +1 per tick plus BCD bonuses, added digit-serially and committed atomically.
// Optional high-score tracking is built when SCORE_HISCORE_EN is defined.
module score_accumulator #(
    parameter int MAX_DIGITS = 6,
    parameter int ADD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    tick,
    input  logic                    add_valid,
    input  logic [4*ADD_DIGITS-1:0] add_value,
    output logic                    add_ready,
    input  logic                    clear,
    output logic [4*MAX_DIGITS-1:0] score,
    output logic                    busy,
    output logic                    saturated
`ifdef SCORE_HISCORE_EN
    ,
    input  logic                    game_over,
    output logic [4*MAX_DIGITS-1:0] hiscore,
    output logic                    new_record
`endif
);

    localparam int W     = 4 * MAX_DIGITS;
    localparam int IDX_W = $clog2(MAX_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DIGITS - 1);
    localparam logic [W-1:0]     ALL_NINES = {MAX_DIGITS{4'h9}};
    localparam logic [W-1:0]     ONE       = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state, state_next;
    logic [W-1:0]     working, op;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             pending_tick, pending_next;
    logic             start, use_bonus, tick_ev, last_digit;
    logic [4:0]       digit_sum;

    function automatic logic [W-1:0] clamp_operand(input logic [4*ADD_DIGITS-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < ADD_DIGITS; i++)
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                 input logic cin);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        t = s - 5'd10;
        if (s > 5'd9)
            return {1'b1, t[3:0]};
        return s;
    endfunction

    // working and op shift right one digit per cycle, so digit 0 is always the one being added
    assign digit_sum  = bcd_digit_add(working[3:0], op[3:0], carry);
    assign last_digit = (idx == LAST_IDX);
    assign tick_ev    = tick && en && !saturated;
    assign busy       = (state == ADD);
    assign add_ready  = (state == IDLE) && !pending_tick && !clear;

    always_comb begin
        state_next   = state;
        pending_next = pending_tick;
        start        = 1'b0;
        use_bonus    = 1'b0;
        if (clear) begin
            state_next   = IDLE;
            pending_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (saturated) begin
                        pending_next = 1'b0;
                    end else if (pending_tick) begin
                        start        = 1'b1;
                        pending_next = 1'b0;
                    end else if (add_valid) begin
                        start        = 1'b1;
                        use_bonus    = 1'b1;
                        pending_next = tick_ev;
                    end else if (tick_ev) begin
                        start = 1'b1;
                    end
                    if (start)
                        state_next = ADD;
                end
                ADD: begin
                    pending_next = pending_tick | tick_ev;
                    if (last_digit) begin
                        state_next = IDLE;
                        // a saturating commit leaves nothing worth adding later
                        if (digit_sum[4])
                            pending_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending_tick <= 1'b0;
            saturated    <= 1'b0;
            score        <= '0;
            idx          <= '0;
            carry        <= 1'b0;
        end else begin
            state        <= state_next;
            pending_tick <= pending_next;
            if (clear) begin
                score     <= '0;
                saturated <= 1'b0;
            end else if (start) begin
                idx   <= '0;
                carry <= 1'b0;
            end else if (state == ADD) begin
                idx   <= idx + 1'b1;
                carry <= digit_sum[4];
                if (last_digit) begin
                    if (digit_sum[4]) begin
                        score     <= ALL_NINES;
                        saturated <= 1'b1;
                    end else begin
                        score <= {digit_sum[3:0], working[W-1:4]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            working <= score;
            op      <= use_bonus ? clamp_operand(add_value) : ONE;
        end else if (state == ADD) begin
            working <= {digit_sum[3:0], working[W-1:4]};
            op      <= {4'h0, op[W-1:4]};
        end
    end

`ifdef SCORE_HISCORE_EN
    logic cmp_pending, cmp_now;

    assign cmp_now = cmp_pending | game_over;

    // compare waits until no addition is in flight so it sees a committed score
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_pending <= 1'b0;
            hiscore     <= '0;
            new_record  <= 1'b0;
        end else begin
            new_record <= 1'b0;
            if (cmp_now && state == IDLE) begin
                cmp_pending <= 1'b0;
                if (score > hiscore) begin
                    hiscore    <= score;
                    new_record <= 1'b1;
                end
            end else begin
                cmp_pending <= cmp_now;
            end
        end
    end
`endif

endmodule
